// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the mem_arbiter slice.
//   arb_state_t    - arbiter FSM state encoding (3-bit)
//   CLI_I / CLI_D  - client-select constants (fetch / data)
//   *_DEF          - default STARVE_MAX / TIMEOUT values
//   wd_width()     - watchdog counter width (at least 6 bits, holds TIMEOUT)
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_I,
        ST_WAIT_I,
        ST_ISSUE_D,
        ST_WAIT_D,
        ST_ERR
    } arb_state_t;

    localparam logic CLI_I = 1'b0;
    localparam logic CLI_D = 1'b1;

    localparam int unsigned STARVE_MAX_DEF = 3;
    localparam int unsigned TIMEOUT_DEF    = 63;

    function automatic int unsigned wd_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 6) ? 6 : w;
    endfunction

endpackage

// File: rtl/arb_req_latch.sv
// arb_req_latch: captures the granted request and holds it stable until the
// next load.
//   clk, rst               - clock, asynchronous active-low reset
//   load                   - capture the cap_* inputs this cycle
//   cap_addr/cap_data      - request address / write data to capture
//   cap_rd/cap_wr          - request read / write strobes to capture
//   addr/data/rd/wr        - held request
module arb_req_latch (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] cap_addr,
    input  logic [15:0] cap_data,
    input  logic        cap_rd,
    input  logic        cap_wr,
    output logic [15:0] addr,
    output logic [15:0] data,
    output logic        rd,
    output logic        wr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
            data <= '0;
            rd   <= 1'b0;
            wr   <= 1'b0;
        end else if (load) begin
            addr <= cap_addr;
            data <= cap_data;
            rd   <= cap_rd;
            wr   <= cap_wr;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (fetch / data) arbiter in front of the unified cache
// controller. One request at a time is latched, issued with a 1-cycle Rd/Wr
// strobe, and held on Addr/DataIn until the controller signals Done.
// Data has priority; after STARVE_MAX consecutive data grants with a fetch
// pending, the fetch is forced. A watchdog raises err after TIMEOUT wait cycles.
//   clk, rst                        - clock, asynchronous active-low reset
//   i_rd/i_addr                     - fetch request
//   i_data/i_done/i_stall           - fetch response / status
//   d_rd/d_wr/d_addr/d_wdata        - data request
//   d_data/d_done/d_stall           - data response / status
//   m_addr/m_datain/m_rd/m_wr       - to controller
//   m_dataout/m_done/m_hit/m_err    - from controller
//   hit                             - CacheHit of last completed transaction
//   err                             - sticky error (cleared only by reset)
// Optional: define ARB_STATS_EN to add stat_clr input and saturating
// stat_hits / stat_miss completion counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_data,
    output logic        d_done,
    output logic        d_stall,
    output logic [15:0] m_addr,
    output logic [15:0] m_datain,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_dataout,
    input  logic        m_done,
    input  logic        m_hit,
    input  logic        m_err,
`ifdef ARB_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_miss,
`endif
    output logic        hit,
    output logic        err
);

    localparam int unsigned SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int unsigned WD_W = wd_width(TIMEOUT);

    arb_state_t      state, state_nxt;
    logic [SC_W-1:0] starve_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic        load, sel;
    logic [15:0] lat_addr, lat_data;
    logic        lat_rd, lat_wr;

    logic i_req, d_req, d_bad, gap;
    logic starve_hit, wd_expire;
    logic in_issue, in_wait, busy, in_i, complete;

    // A client whose done pulse is showing still holds its old request; mask it.
    assign i_req      = i_rd & ~i_done;
    assign d_req      = (d_rd | d_wr) & ~d_done;
    assign d_bad      = d_rd & d_wr;
    // Any done pulse marks the mandatory one-cycle IDLE gap.
    assign gap        = i_done | d_done;
    assign starve_hit = (starve_cnt == SC_W'(STARVE_MAX));
    assign wd_expire  = (wd_cnt == WD_W'(TIMEOUT - 1));

    assign in_issue = (state == ST_ISSUE_I) || (state == ST_ISSUE_D);
    assign in_wait  = (state == ST_WAIT_I)  || (state == ST_WAIT_D);
    assign busy     = in_issue | in_wait;
    assign in_i     = (state == ST_ISSUE_I) || (state == ST_WAIT_I);
    assign complete = busy & m_done;

    assign i_stall = rst & i_rd & ~i_done;
    assign d_stall = rst & (d_rd | d_wr) & ~d_done;

    assign m_addr   = busy ? lat_addr : '0;
    assign m_datain = busy ? lat_data : '0;
    assign m_rd     = in_issue & lat_rd;
    assign m_wr     = in_issue & lat_wr;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sel       = CLI_D;
        case (state)
            ST_IDLE: begin
                if (d_bad) begin
                    state_nxt = ST_ERR;
                end else if (!gap) begin
                    if (d_req && !(i_req && starve_hit)) begin
                        state_nxt = ST_ISSUE_D;
                        load      = 1'b1;
                        sel       = CLI_D;
                    end else if (i_req) begin
                        state_nxt = ST_ISSUE_I;
                        load      = 1'b1;
                        sel       = CLI_I;
                    end
                end
            end
            ST_ISSUE_I, ST_ISSUE_D: begin
                if (m_done)
                    state_nxt = ST_IDLE;
                else if (m_err)
                    state_nxt = ST_ERR;
                else
                    state_nxt = (state == ST_ISSUE_I) ? ST_WAIT_I : ST_WAIT_D;
            end
            ST_WAIT_I, ST_WAIT_D: begin
                if (m_done)
                    state_nxt = ST_IDLE;
                else if (m_err || wd_expire)
                    state_nxt = ST_ERR;
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_ERR;
        endcase
    end

    arb_req_latch u_req_latch (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cap_addr ((sel == CLI_I) ? i_addr : d_addr),
        .cap_data ((sel == CLI_I) ? 16'h0000 : d_wdata),
        .cap_rd   ((sel == CLI_I) ? 1'b1 : d_rd),
        .cap_wr   ((sel == CLI_I) ? 1'b0 : d_wr),
        .addr     (lat_addr),
        .data     (lat_data),
        .rd       (lat_rd),
        .wr       (lat_wr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_data     <= '0;
            i_done     <= 1'b0;
            d_data     <= '0;
            d_done     <= 1'b0;
            hit        <= 1'b0;
            err        <= 1'b0;
            starve_cnt <= '0;
            wd_cnt     <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            if (complete) begin
                hit <= m_hit;
                if (in_i) begin
                    i_data <= m_dataout;
                    i_done <= 1'b1;
                end else begin
                    d_data <= m_dataout;
                    d_done <= 1'b1;
                end
            end
            if (state_nxt == ST_ERR)
                err <= 1'b1;

            if (state == ST_ISSUE_I || !i_rd)
                starve_cnt <= '0;
            else if (state == ST_ISSUE_D && !starve_hit)
                starve_cnt <= starve_cnt + 1'b1;

            if (in_issue)
                wd_cnt <= '0;
            else if (in_wait)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits <= '0;
            stat_miss <= '0;
        end else if (stat_clr) begin
            stat_hits <= '0;
            stat_miss <= '0;
        end else if (complete) begin
            if (m_hit && stat_hits != '1)
                stat_hits <= stat_hits + 1'b1;
            if (!m_hit && stat_miss != '1)
                stat_miss <= stat_miss + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_rd = 1'b0;
    logic [15:0] i_addr = '0;
    logic [15:0] i_data;
    logic        i_done, i_stall;
    logic        d_rd = 1'b0, d_wr = 1'b0;
    logic [15:0] d_addr = '0, d_wdata = '0;
    logic [15:0] d_data;
    logic        d_done, d_stall;
    logic [15:0] m_addr, m_datain;
    logic        m_rd, m_wr;
    logic [15:0] m_dataout = '0;
    logic        m_done = 1'b0, m_hit = 1'b0, m_err = 1'b0;
    logic        hit, err;
`ifdef ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_hits, stat_miss;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(3), .TIMEOUT(63)) dut (
        .clk(clk), .rst(rst),
        .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data), .i_done(i_done), .i_stall(i_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_data(d_data), .d_done(d_done), .d_stall(d_stall),
        .m_addr(m_addr), .m_datain(m_datain), .m_rd(m_rd), .m_wr(m_wr),
        .m_dataout(m_dataout), .m_done(m_done), .m_hit(m_hit), .m_err(m_err),
`ifdef ARB_STATS_EN
        .stat_clr(stat_clr), .stat_hits(stat_hits), .stat_miss(stat_miss),
`endif
        .hit(hit), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_rd = 0; d_rd = 0; d_wr = 0; m_done = 0; m_err = 0; m_hit = 0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({m_rd, m_wr, m_addr, m_datain} !== 34'd0) begin errors++;
            $display("FAIL reset_m got %h exp 0", {m_rd, m_wr, m_addr, m_datain}); end
        checks++; if ({i_done, d_done, i_stall, d_stall, hit, err} !== 6'd0) begin errors++;
            $display("FAIL reset_flags got %b exp 000000", {i_done, d_done, i_stall, d_stall, hit, err}); end
        checks++; if ({i_data, d_data} !== 32'd0) begin errors++;
            $display("FAIL reset_data got %h exp 0", {i_data, d_data}); end
    endtask

    task automatic test_fetch();
        i_rd = 1; i_addr = 16'h0040;
        #1;
        checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall got %b exp 1", i_stall); end
        tick();  // ISSUE_I
        checks++; if ({m_rd, m_wr, m_addr} !== {2'b10, 16'h0040}) begin errors++;
            $display("FAIL fetch_issue got %h exp 20040", {m_rd, m_wr, m_addr}); end
        tick();  // WAIT_I, cycle 0
        for (int k = 0; k < 3; k++) begin
            checks++; if ({m_rd, m_addr} !== {1'b0, 16'h0040}) begin errors++;
                $display("FAIL fetch_hold got %h exp 00040", {m_rd, m_addr}); end
            tick();
        end
        m_done = 1; m_dataout = 16'hBEEF; m_hit = 1;
        tick();  // IDLE, done pulse
        m_done = 0;
        checks++; if ({i_done, i_data} !== {1'b1, 16'hBEEF}) begin errors++;
            $display("FAIL fetch_done got %h exp 1beef", {i_done, i_data}); end
        checks++; if ({hit, i_stall, m_addr} !== {2'b10, 16'h0000}) begin errors++;
            $display("FAIL fetch_idle got %h exp 20000", {hit, i_stall, m_addr}); end
        i_rd = 0;
        tick();
        checks++; if ({i_done, i_stall, m_rd} !== 3'b000) begin errors++;
            $display("FAIL fetch_after got %b exp 000", {i_done, i_stall, m_rd}); end
    endtask

    task automatic test_store();
        d_wr = 1; d_addr = 16'h1002; d_wdata = 16'h1234;
        tick();  // ISSUE_D
        d_wdata = 16'hFFFF;  // must be ignored once latched
        checks++; if ({m_rd, m_wr, m_addr, m_datain} !== {2'b01, 16'h1002, 16'h1234}) begin errors++;
            $display("FAIL store_issue got %h exp 110021234", {m_rd, m_wr, m_addr, m_datain}); end
        tick();  // WAIT_D
        checks++; if ({m_wr, m_datain} !== {1'b0, 16'h1234}) begin errors++;
            $display("FAIL store_hold got %h exp 01234", {m_wr, m_datain}); end
        m_done = 1; m_hit = 0; m_dataout = 16'h0000;
        tick();
        m_done = 0;
        checks++; if ({d_done, hit, d_stall, m_datain} !== {3'b100, 16'h0000}) begin errors++;
            $display("FAIL store_done got %h exp 40000", {d_done, hit, d_stall, m_datain}); end
        d_wr = 0;
        tick();
        checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL store_pulse got %b exp 0", d_done); end
    endtask

    task automatic test_zero_wait();
        d_rd = 1; d_addr = 16'h2000;
        tick();  // ISSUE_D
        checks++; if (m_rd !== 1'b1) begin errors++; $display("FAIL zw_issue got %b exp 1", m_rd); end
        m_done = 1; m_hit = 1; m_dataout = 16'h5A5A;
        tick();
        m_done = 0;
        checks++; if ({d_done, d_data, hit} !== {1'b1, 16'h5A5A, 1'b1}) begin errors++;
            $display("FAIL zw_done got %h exp 2b4b5", {d_done, d_data, hit}); end
        d_rd = 0;
        tick();
    endtask

    task automatic test_contention();
        logic [15:0] exp_g [8];
        int n;
        exp_g = '{16'h0200, 16'h0200, 16'h0200, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0100};
        n = 0;
        i_rd = 1; i_addr = 16'h0100; d_rd = 1; d_addr = 16'h0200; m_hit = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            tick();
            m_done = m_rd;  // zero-wait completion of every grant
            if (m_rd) begin
                checks++; if (m_addr !== exp_g[n]) begin errors++;
                    $display("FAIL grant%0d got %h exp %h", n, m_addr, exp_g[n]); end
                n++;
            end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL grant_budget got %0d exp 8", n); end
        tick();
        m_done = 0; i_rd = 0; d_rd = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        i_rd = 1; i_addr = 16'h0300;
        tick();
        tick();  // WAIT_I
        #2 rst = 1'b0;
        #1;
        checks++; if ({m_rd, m_addr, i_stall, i_done, err} !== 20'd0) begin errors++;
            $display("FAIL rstmid_async got %h exp 0", {m_rd, m_addr, i_stall, i_done, err}); end
        tick();
        rst = 1'b1;
        tick();  // fresh grant
        checks++; if ({m_rd, m_addr} !== {1'b1, 16'h0300}) begin errors++;
            $display("FAIL rstmid_regrant got %h exp 10300", {m_rd, m_addr}); end
        m_done = 1; m_dataout = 16'h7777;
        tick();
        m_done = 0;
        checks++; if ({i_done, i_data} !== {1'b1, 16'h7777}) begin errors++;
            $display("FAIL rstmid_done got %h exp 17777", {i_done, i_data}); end
        i_rd = 0;
        tick();
    endtask

    task automatic test_watchdog();
        int early;
        early = 0;
        d_rd = 1; d_addr = 16'h0400;
        tick();  // ISSUE_D
        tick();  // WAIT_D entry
        for (int k = 1; k < 63; k++) begin
            tick();
            if (err !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL wd_early got %0d exp 0", early); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err got %b exp 1", err); end
        checks++; if ({m_rd, m_wr, m_addr} !== 18'd0) begin errors++;
            $display("FAIL wd_strobes got %h exp 0", {m_rd, m_wr, m_addr}); end
        do_reset();
    endtask

    task automatic test_err_paths();
        int strobes;
        // illegal simultaneous read/write
        d_rd = 1; d_wr = 1;
        tick();
        checks++; if ({err, m_rd, m_wr} !== 3'b100) begin errors++;
            $display("FAIL bad_req got %b exp 100", {err, m_rd, m_wr}); end
        d_wr = 0; strobes = 0;
        for (int k = 0; k < 5; k++) begin tick(); strobes += int'(m_rd | m_wr); end
        checks++; if ({strobes, err} !== {32'd0, 1'b1}) begin errors++;
            $display("FAIL bad_req_sticky got strobes %0d err %b exp 0 1", strobes, err); end
        do_reset();
        // controller error during WAIT_D
        d_rd = 1; d_addr = 16'h0500;
        tick();
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL merr_pre got %b exp 0", err); end
        m_err = 1;
        tick();
        m_err = 0; i_rd = 1; strobes = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL merr_err got %b exp 1", err); end
        for (int k = 0; k < 5; k++) begin tick(); strobes += int'(m_rd | m_wr); end
        checks++; if (strobes != 0) begin errors++; $display("FAIL merr_strobes got %0d exp 0", strobes); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_zero_wait();
        test_contention();
        test_reset_mid();
        test_watchdog();
        test_err_paths();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
